pc_fetch_unit: RTL and testbench

Producer side of the fetch-to-decode boundary.
- Owns the PC register and issues word addresses to the synchronous instruction ROM (1-cycle read latency).
- Presents {pc_o, inst_o, valid_o} to the IF/ID pipeline register.
- Honours the same pause (stall) and redirect (flush) signals the IF/ID register receives.
- A one-entry hold buffer keeps the returning instruction safe while stalled, so no fetch is lost or duplicated.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_hold_buf.sv | 45 ++++
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its hold buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {valid, pc, inst} buffer that parks a returning instruction while fetch is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // A flush wipes the entry completely so a wrong-path pair never lingers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (load_i) begin
      valid_q <= valid_i;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, ROM request issue and stall/redirect handling for the fetch-to-decode boundary.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IROM_ADDR_W = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pause_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [IROM_ADDR_W-1:0] irom_addr_o,
  input  logic [31:0]            irom_data_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            inst_o,
  output logic                   valid_o,
  output logic [31:0]            fetch_cnt_o,
  output logic [31:0]            stall_cnt_o
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         infl_v_q;
  logic [31:0]  infl_pc_q;

  logic         hb_valid;
  logic [31:0]  hb_pc;
  logic [31:0]  hb_inst;

  logic         redirect_act;
  logic [31:0]  target_pc;
  logic         pres_v;
  logic [31:0]  pres_pc;
  logic [31:0]  pres_inst;

  // Redirects arriving before the first request has been issued are ignored.
  assign redirect_act = redirect_i && (state_q != BOOT);
  assign target_pc    = align_pc(redirect_pc_i);

  fetch_hold_buf u_hold_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  ((state_q == RUN) && !redirect_act && pause_i),
    .clear_i ((state_q == HOLD) && !redirect_act && !pause_i),
    .flush_i (redirect_act),
    .valid_i (infl_v_q),
    .pc_i    (infl_pc_q),
    .inst_i  (irom_data_i),
    .valid_o (hb_valid),
    .pc_o    (hb_pc),
    .inst_o  (hb_inst)
  );

  always_comb begin
    pres_v    = 1'b0;
    pres_pc   = '0;
    pres_inst = NOP_INST;
    case (state_q)
      RUN: begin
        pres_v    = infl_v_q;
        pres_pc   = infl_pc_q;
        pres_inst = irom_data_i;
      end
      HOLD: begin
        pres_v    = hb_valid;
        pres_pc   = hb_pc;
        pres_inst = hb_inst;
      end
      default: ;
    endcase
  end

  // A wrong-path pair is replaced by a clean bubble.
  assign valid_o     = pres_v && !redirect_act;
  assign pc_o        = valid_o ? pres_pc : 32'h0;
  assign inst_o      = valid_o ? pres_inst : NOP_INST;
  assign irom_addr_o = redirect_act ? target_pc[IROM_ADDR_W+1:2] : pc_q[IROM_ADDR_W+1:2];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      infl_v_q  <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          infl_v_q  <= 1'b1;
          infl_pc_q <= pc_q;
          pc_q      <= pc_q + PC_STEP;
          state_q   <= RUN;
        end
        RUN, HOLD: begin
          if (redirect_act) begin
            infl_v_q  <= 1'b1;
            infl_pc_q <= target_pc;
            pc_q      <= target_pc + PC_STEP;
            state_q   <= RUN;
          end else if (pause_i) begin
            // No new request while the current response is parked.
            state_q <= HOLD;
          end else begin
            infl_v_q  <= 1'b1;
            infl_pc_q <= pc_q;
            pc_q      <= pc_q + PC_STEP;
            state_q   <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_o && !pause_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == HOLD) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = 32'h0;
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised self-checking bench for pc_fetch_unit against a stream-level model of the fetch sequence.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 14;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          pause_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [AW-1:0] irom_addr_o;
  logic [31:0]   irom_data_i;
  logic [31:0]   pc_o;
  logic [31:0]   inst_o;
  logic          valid_o;
  logic [31:0]   fetch_cnt_o;
  logic [31:0]   stall_cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: the stream of presented instructions, not the fetch pipeline.
  bit          m_boot;
  bit          m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IROM_ADDR_W(AW)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pause_i       (pause_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .irom_addr_o   (irom_addr_o),
    .irom_data_i   (irom_data_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous ROM: word i holds i + 0x100.
  always @(posedge clk_i) irom_data_i <= {18'b0, irom_addr_o} + 32'h100;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {18'b0, pc[15:2]};
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] pc);
    return word_of(pc) + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_counters();
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, m_fcnt);
    chk("stall_cnt", stall_cnt_o, m_scnt);
`else
    chk("fetch_cnt", fetch_cnt_o, 32'h0);
    chk("stall_cnt", stall_cnt_o, 32'h0);
`endif
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_hold = 1'b0;
    m_pc   = RESET_PC;
    m_fcnt = '0;
    m_scnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_addr", {18'b0, irom_addr_o}, word_of(RESET_PC));
    chk_counters();
    $display("cyc %0d reset asserted", cyc);
  endtask

  task automatic cycle(input bit p, input bit r, input logic [31:0] t);
    bit          exp_v;
    logic [31:0] exp_addr;
    @(negedge clk_i);
    rst_n_i       = 1'b1;
    pause_i       = p;
    redirect_i    = r;
    redirect_pc_i = t;
    #1;
    exp_v    = !m_boot && !r;
    exp_addr = m_boot ? word_of(RESET_PC) : (r ? word_of(t) : word_of(m_pc + 32'd4));
    chk("valid", {31'b0, valid_o}, {31'b0, exp_v});
    chk("addr", {18'b0, irom_addr_o}, exp_addr);
    if (exp_v) begin
      chk("pc", pc_o, m_pc);
      chk("inst", inst_o, rom_at(m_pc));
    end else begin
      chk("bubble_inst", inst_o, 32'h0);
    end
    chk_counters();
    $display("cyc %0d p=%0b r=%0b t=%h -> v=%0b pc=%h inst=%h addr=%h", cyc, p, r, t,
             valid_o, pc_o, inst_o, irom_addr_o);
    @(posedge clk_i);
    cyc++;
    if (exp_v && !p) m_fcnt++;
    if (m_hold) m_scnt++;
    if (m_boot) begin
      m_boot = 1'b0;
      m_hold = 1'b0;
      m_pc   = RESET_PC;
    end else if (r) begin
      m_pc   = t & 32'hFFFF_FFFC;
      m_hold = 1'b0;
    end else if (p) begin
      m_hold = 1'b1;
    end else begin
      m_pc   = m_pc + 32'd4;
      m_hold = 1'b0;
    end
  endtask

  initial begin
    rst_n_i       = 1'b0;
    pause_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    do_reset();

    // Boot then pc 0, 4; stall three cycles on pc 8; continue to 0x10.
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    // Redirect while presenting 0x10.
    cycle(0, 1, 32'h40);
    repeat (3) cycle(0, 0, 0);
    // Redirect plus pause while in HOLD, unaligned target.
    repeat (2) cycle(1, 0, 0);
    cycle(1, 1, 32'h21);
    repeat (2) cycle(0, 0, 0);
    // Wrap around the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFC);
    repeat (3) cycle(0, 0, 0);
    // Reset mid-stall.
    repeat (2) cycle(1, 0, 0);
    do_reset();
    repeat (4) cycle(0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
              ($urandom_range(0, 3) == 0) ? $urandom : {16'h0, 16'($urandom)});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
